// File: rtl/freq_pkg.sv
// Shared encodings for the frequency meter gate controller: FSM state codes
// and measurement range limits.
package freq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int RANGE_W = 2;
    localparam logic [RANGE_W-1:0] RANGE_MAX = 2'd3;

endpackage

// File: rtl/freq_gate_ctrl_phase_tick_cnt.sv
// Phase length counter: counts timebase ticks and flags the tick that ends
// the current phase. The counter wraps to zero on that tick.
module phase_tick_cnt
    import freq_pkg::*;
#(
    parameter int TICK_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              tick_i,
    input  logic [TICK_W-1:0] len_i,
    output logic              term_o
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    assign term_o = tick_i && (cnt_q == (len_i - TICK_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = term_o ? '0 : cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate/sequence controller for the frequency meter: IDLE -> CLEAR -> COUNT
// -> LATCH driven by timebase ticks, with continuous mode and overflow auto-ranging.
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int TICK_W      = 8,
    parameter int GATE0       = 1,
    parameter int GATE1       = 10,
    parameter int GATE2       = 100,
    parameter int GATE3       = 250,
    parameter int CLR_TICKS   = 1,
    parameter int LATCH_TICKS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic               auto_en,
    input  logic [RANGE_W-1:0] range_sel,
    input  logic               ovf,
    output logic               cnt_clr_n,
    output logic               cnt_en,
    output logic               latch,
    output logic [RANGE_W-1:0] range_q,
    output logic               ovf_q,
    output logic               done,
    output logic               busy
);

    localparam int LEN_LIM = 1 << TICK_W;

    if (GATE0 < 1 || GATE1 < 1 || GATE2 < 1 || GATE3 < 1 ||
        CLR_TICKS < 1 || LATCH_TICKS < 1) begin : g_len_zero
        $error("freq_gate_ctrl: phase lengths must be at least 1 tick");
    end

    if (GATE0 >= LEN_LIM || GATE1 >= LEN_LIM || GATE2 >= LEN_LIM ||
        GATE3 >= LEN_LIM || CLR_TICKS >= LEN_LIM || LATCH_TICKS >= LEN_LIM) begin : g_len_wide
        $error("freq_gate_ctrl: phase length does not fit in TICK_W bits");
    end

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [RANGE_W-1:0] range_d;
    logic [RANGE_W-1:0] start_range;
    logic               sticky_q;
    logic               sticky_d;
    logic               ovf_d;
    logic               done_d;
    logic               cnt_clr_n_d;
    logic               cnt_en_d;
    logic               latch_d;
    logic               busy_d;
    logic [TICK_W-1:0]  gate_len;
    logic [TICK_W-1:0]  phase_len;
    logic               cnt_clr;
    logic               term;

    assign start_range = auto_en ? RANGE_MAX : range_sel;

    always_comb begin
        unique case (range_q)
            2'd0:    gate_len = TICK_W'(GATE0);
            2'd1:    gate_len = TICK_W'(GATE1);
            2'd2:    gate_len = TICK_W'(GATE2);
            default: gate_len = TICK_W'(GATE3);
        endcase
    end

    always_comb begin
        unique case (state_q)
            ST_CLEAR: phase_len = TICK_W'(CLR_TICKS);
            ST_COUNT: phase_len = gate_len;
            ST_LATCH: phase_len = TICK_W'(LATCH_TICKS);
            default:  phase_len = TICK_W'(1);
        endcase
    end

    // Holding the counter clear in IDLE means a tick coinciding with start is never counted.
    assign cnt_clr = (state_q == ST_IDLE) || stop;

    phase_tick_cnt #(
        .TICK_W (TICK_W)
    ) u_phase_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr),
        .tick_i (tick),
        .len_i  (phase_len),
        .term_o (term)
    );

    always_comb begin
        state_d  = state_q;
        range_d  = range_q;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_CLEAR;
                        range_d  = start_range;
                        sticky_d = 1'b0;
                        ovf_d    = 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (term) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Fold in this cycle's ovf so an overflow on the terminal tick still counts.
                    sticky_d = sticky_q | ovf;
                    if (term) begin
                        if (sticky_d && auto_en && (range_q != '0)) begin
                            state_d  = ST_CLEAR;
                            range_d  = range_q - RANGE_W'(1);
                            sticky_d = 1'b0;
                        end else begin
                            state_d = ST_LATCH;
                            ovf_d   = sticky_d;
                        end
                    end
                end
                default: begin
                    if (term) begin
                        done_d = 1'b1;
                        if (cont) begin
                            state_d  = ST_CLEAR;
                            range_d  = start_range;
                            sticky_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as state_q.
    always_comb begin
        cnt_clr_n_d = (state_d == ST_COUNT) || (state_d == ST_LATCH);
        cnt_en_d    = (state_d == ST_COUNT);
        latch_d     = (state_d == ST_LATCH);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            range_q   <= '0;
            sticky_q  <= 1'b0;
            ovf_q     <= 1'b0;
            done      <= 1'b0;
            cnt_clr_n <= 1'b0;
            cnt_en    <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            range_q   <= range_d;
            sticky_q  <= sticky_d;
            ovf_q     <= ovf_d;
            done      <= done_d;
            cnt_clr_n <= cnt_clr_n_d;
            cnt_en    <= cnt_en_d;
            latch     <= latch_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed testbench for freq_gate_ctrl with default parameters
// (gates 1/10/100/250 ticks, one-tick CLEAR and LATCH).
module tb_freq_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       start;
    logic       stop;
    logic       cont;
    logic       auto_en;
    logic [1:0] range_sel;
    logic       ovf;
    logic       cnt_clr_n;
    logic       cnt_en;
    logic       latch;
    logic [1:0] range_q;
    logic       ovf_q;
    logic       done;
    logic       busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    freq_gate_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .cont      (cont),
        .auto_en   (auto_en),
        .range_sel (range_sel),
        .ovf       (ovf),
        .cnt_clr_n (cnt_clr_n),
        .cnt_en    (cnt_en),
        .latch     (latch),
        .range_q   (range_q),
        .ovf_q     (ovf_q),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Observed phase: 0 idle, 1 clear, 2 count, 3 latch.
    function automatic int st_of();
        if (!busy) return 0;
        if (latch) return 3;
        if (cnt_en) return 2;
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    // Starts a measurement with a tick every cycle and runs it to its done pulse.
    // ovf is driven during the first ovf_phases COUNT phases.
    task automatic run_meas(input int ovf_phases, input int budget,
                            output int phases, output logic [7:0] hist,
                            output int latch_cyc, output int done_cyc,
                            output bit fin);
        int st;
        int prev;
        phases    = 0;
        hist      = '0;
        latch_cyc = 0;
        done_cyc  = 0;
        fin       = 1'b0;
        start     = 1'b1;
        step();
        prev = 0;
        for (int i = 0; i < budget && !fin; i++) begin
            st = st_of();
            if (st == 2 && prev != 2) begin
                phases++;
                if (phases <= 4) hist[2*(phases-1) +: 2] = range_q;
            end
            ovf  = (st == 2) && (phases <= ovf_phases);
            tick = 1'b1;
            prev = st;
            step();
            if (latch) latch_cyc++;
            if (done) begin
                done_cyc++;
                fin = 1'b1;
            end
        end
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            step();
            if (done) done_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 0; start = 0; stop = 0; cont = 0;
        auto_en = 0; range_sel = 2'd0; ovf = 0;
        #12;
        chk_cnt++;
        if ({cnt_clr_n, cnt_en, latch, range_q, ovf_q, done, busy} !== 8'b0)
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {cnt_clr_n, cnt_en, latch, range_q, ovf_q, done, busy});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick = 1'b1;
        step();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle_hold: busy=%b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_single_shot();
        int clr_t = 0, en_t = 0, lat_t = 0, done_c = 0, done_busy = 0, st;
        range_sel = 2'd1; cont = 0; auto_en = 0;
        for (int i = 0; i < 80; i++) begin
            start = (i == 0);
            tick  = (i % 4 == 3);
            st = st_of();
            if (tick) begin
                if (st == 1) clr_t++;
                if (st == 2) en_t++;
                if (st == 3) lat_t++;
            end
            step();
            if (done) begin
                done_c++;
                if (busy) done_busy++;
            end
        end
        chk_cnt++;
        if (clr_t !== 1) $display("FAIL ss_clear_ticks: got %0d expected 1", clr_t);
        else pass_cnt++;
        chk_cnt++;
        if (en_t !== 10) $display("FAIL ss_count_ticks: got %0d expected 10", en_t);
        else pass_cnt++;
        chk_cnt++;
        if (lat_t !== 1) $display("FAIL ss_latch_ticks: got %0d expected 1", lat_t);
        else pass_cnt++;
        chk_cnt++;
        if (done_c !== 1) $display("FAIL ss_done_count: got %0d expected 1", done_c);
        else pass_cnt++;
        chk_cnt++;
        if (done_busy !== 0) $display("FAIL ss_done_with_busy: got %0d expected 0", done_busy);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, range_q, ovf_q} !== 4'b0010)
            $display("FAIL ss_final: busy/range/ovf_q got %b expected 0010", {busy, range_q, ovf_q});
        else pass_cnt++;
    endtask

    task automatic test_continuous();
        int exp_st;
        cont = 1; range_sel = 2'd0; auto_en = 0;
        start = 1'b1;
        step();
        chk_cnt++;
        if (st_of() !== 1) $display("FAIL cont_start: phase got %0d expected 1", st_of());
        else pass_cnt++;
        for (int k = 1; k <= 8; k++) begin
            exp_st = (k % 3 == 1) ? 2 : (k % 3 == 2) ? 3 : 1;
            tick = 1'b1;
            step();
            chk_cnt++;
            if (st_of() !== exp_st || done !== (k % 3 == 0))
                $display("FAIL cont_tick%0d: phase/done got %0d/%b expected %0d/%b",
                         k, st_of(), done, exp_st, (k % 3 == 0));
            else pass_cnt++;
            step();
            chk_cnt++;
            if (done !== 1'b0) $display("FAIL cont_gap%0d: done got %b expected 0", k, done);
            else pass_cnt++;
        end
        stop = 1'b1;
        tick = 1'b1;
        step();
        chk_cnt++;
        if ({busy, cnt_clr_n, cnt_en, latch, done, range_q} !== 7'b0)
            $display("FAIL cont_stop: got %b expected 0000000",
                     {busy, cnt_clr_n, cnt_en, latch, done, range_q});
        else pass_cnt++;
        cont = 0;
    endtask

    task automatic test_auto_range();
        int phases, latch_cyc, done_cyc;
        logic [7:0] hist;
        bit fin;
        auto_en = 1; range_sel = 2'd0;
        run_meas(2, 1000, phases, hist, latch_cyc, done_cyc, fin);
        chk_cnt++;
        if (fin !== 1'b1) $display("FAIL auto_timeout: done seen %b expected 1", fin);
        else pass_cnt++;
        chk_cnt++;
        if (phases !== 3 || hist[5:0] !== 6'b01_10_11)
            $display("FAIL auto_ranges: phases %0d hist %b expected 3 011011", phases, hist[5:0]);
        else pass_cnt++;
        chk_cnt++;
        if (latch_cyc !== 1 || done_cyc !== 1)
            $display("FAIL auto_latch_done: latch %0d done %0d expected 1 1", latch_cyc, done_cyc);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, range_q, ovf_q} !== 4'b0010)
            $display("FAIL auto_final: busy/range/ovf_q got %b expected 0010", {busy, range_q, ovf_q});
        else pass_cnt++;
    endtask

    task automatic test_ovf_floor();
        int phases, latch_cyc, done_cyc;
        logic [7:0] hist;
        bit fin;
        auto_en = 1;
        run_meas(99, 1000, phases, hist, latch_cyc, done_cyc, fin);
        chk_cnt++;
        if (!fin || phases !== 4 || hist !== 8'b00_01_10_11)
            $display("FAIL floor_ranges: fin %b phases %0d hist %b expected 1 4 00011011", fin, phases, hist);
        else pass_cnt++;
        chk_cnt++;
        if ({range_q, ovf_q, latch_cyc[3:0], done_cyc[3:0]} !== 11'b00_1_0001_0001)
            $display("FAIL floor_result: range %0d ovf_q %b latch %0d done %0d expected 0 1 1 1",
                     range_q, ovf_q, latch_cyc, done_cyc);
        else pass_cnt++;
        auto_en = 0; range_sel = 2'd1;
        run_meas(99, 1000, phases, hist, latch_cyc, done_cyc, fin);
        chk_cnt++;
        if (!fin || phases !== 1 || hist[1:0] !== 2'd1)
            $display("FAIL manual_ovf_noretry: fin %b phases %0d range %0d expected 1 1 1", fin, phases, hist[1:0]);
        else pass_cnt++;
        chk_cnt++;
        if ({range_q, ovf_q, latch_cyc[3:0], done_cyc[3:0]} !== 11'b01_1_0001_0001)
            $display("FAIL manual_ovf_result: range %0d ovf_q %b latch %0d done %0d expected 1 1 1 1",
                     range_q, ovf_q, latch_cyc, done_cyc);
        else pass_cnt++;
    endtask

    task automatic test_edges();
        auto_en = 0; range_sel = 2'd0; cont = 0;
        start = 1'b1;
        step();
        chk_cnt++;
        if (st_of() !== 1 || ovf_q !== 1'b0)
            $display("FAIL edge_start_clears_ovf: phase %0d ovf_q %b expected 1 0", st_of(), ovf_q);
        else pass_cnt++;
        ovf = 1'b1;
        step();
        ovf = 1'b0;
        tick = 1'b1; step();
        tick = 1'b1; step();
        chk_cnt++;
        if (latch !== 1'b1 || ovf_q !== 1'b0)
            $display("FAIL edge_ovf_outside_count: latch %b ovf_q %b expected 1 0", latch, ovf_q);
        else pass_cnt++;
        tick = 1'b1; step();
        start = 1'b1; step();
        tick = 1'b1; step();
        ovf = 1'b1; tick = 1'b1; step();
        ovf = 1'b0;
        chk_cnt++;
        if (latch !== 1'b1 || ovf_q !== 1'b1)
            $display("FAIL edge_ovf_on_terminal: latch %b ovf_q %b expected 1 1", latch, ovf_q);
        else pass_cnt++;
        tick = 1'b1; step();
        start = 1'b1; stop = 1'b1; step();
        chk_cnt++;
        if (busy !== 1'b0 || cnt_clr_n !== 1'b0)
            $display("FAIL edge_start_stop: busy %b clr_n %b expected 0 0", busy, cnt_clr_n);
        else pass_cnt++;
        start = 1'b1; tick = 1'b1; step();
        chk_cnt++;
        if (st_of() !== 1) $display("FAIL edge_start_tick: phase %0d expected 1", st_of());
        else pass_cnt++;
        step();
        chk_cnt++;
        if (st_of() !== 1) $display("FAIL edge_clear_wait: phase %0d expected 1", st_of());
        else pass_cnt++;
        tick = 1'b1; step();
        chk_cnt++;
        if (st_of() !== 2) $display("FAIL edge_clear_to_count: phase %0d expected 2", st_of());
        else pass_cnt++;
        stop = 1'b1; step();
    endtask

    task automatic test_async_reset();
        range_sel = 2'd3; auto_en = 0;
        start = 1'b1; step();
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; step();
        end
        chk_cnt++;
        if (cnt_en !== 1'b1 || range_q !== 2'd3)
            $display("FAIL arst_pre: cnt_en %b range %0d expected 1 3", cnt_en, range_q);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({cnt_clr_n, cnt_en, latch, range_q, ovf_q, done, busy} !== 8'b0)
            $display("FAIL arst_mid_count: got %b expected 00000000",
                     {cnt_clr_n, cnt_en, latch, range_q, ovf_q, done, busy});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL arst_release: busy %b expected 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_auto_range();
        test_ovf_floor();
        test_edges();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
